ps_arbiter: RTL and testbench



---
 rtl/ps_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 46 ++++
 rtl/ps_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ps_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps_arb_pkg
// Purpose : Shared types for the ps_if round-robin arbiter.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package ps_arb_pkg;

  // Arbiter FSM states. IDLE is the only arbitration point; the other
  // states each own exactly one ps_if channel of the granted requester.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RRESP = 3'd4
  } ps_arb_state_e;

endpackage : ps_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin picker. Returns the first set bit of
//           req at or after ptr, wrapping modulo NUM_REQ.
// Ports   : req   in  [NUM_REQ]  request vector
//           ptr   in  [IDX_W]    search start index (must be < NUM_REQ)
//           idx   out [IDX_W]    winning index (0 when nothing found)
//           found out 1          at least one request is set
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the offsets from farthest to nearest so the nearest hit at or
  // after ptr overwrites any farther one and wins.
  always_comb begin
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        idx   = cand_idx;
        found = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/ps_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ps_arbiter
// Purpose : Round-robin arbiter sharing one downstream ps_if slave among
//           NUM_REQ upstream masters. One transaction outstanding at a time;
//           responses route only to the granted requester.
// Ports   : clk, rst                      clock, sync active-high reset
//           s_* (packed [NUM_REQ] arrays)  upstream requester channels
//           m_*                            downstream slave channels
//           grant_idx out [IDX_W]          current/last granted requester
//           busy      out 1                FSM not in IDLE
// Rev     : 1.0  initial release
// ============================================================================
module ps_arbiter
  import ps_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  // upstream requester outputs
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   s_waddr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   s_wdata,
  input  logic [NUM_REQ-1:0]                   s_wvalid,
  input  logic [NUM_REQ-1:0]                   s_bready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   s_raddr,
  input  logic [NUM_REQ-1:0]                   s_arvalid,
  input  logic [NUM_REQ-1:0]                   s_rready,
  // upstream responses
  output logic [NUM_REQ-1:0]                   s_wready,
  output logic [NUM_REQ-1:0]                   s_bvalid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   s_bdata,
  output logic [NUM_REQ-1:0]                   s_aready,
  output logic [NUM_REQ-1:0]                   s_rvalid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   s_rdata,
  // downstream slave
  output logic [ADDR_WIDTH-1:0]                m_waddr,
  output logic [DATA_WIDTH-1:0]                m_wdata,
  output logic                                 m_wvalid,
  output logic                                 m_bready,
  output logic [ADDR_WIDTH-1:0]                m_raddr,
  output logic                                 m_arvalid,
  output logic                                 m_rready,
  input  logic                                 m_wready,
  input  logic                                 m_bvalid,
  input  logic [DATA_WIDTH-1:0]                m_bdata,
  input  logic                                 m_aready,
  input  logic                                 m_rvalid,
  input  logic [DATA_WIDTH-1:0]                m_rdata,
  // status
  output logic [IDX_W-1:0]                     grant_idx,
  output logic                                 busy
);

  ps_arb_state_e    state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic             busy_q;

  logic [NUM_REQ-1:0] req;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [IDX_W-1:0]   rr_ptr_d;

  // A requester competes if it has either channel pending; the
  // write-over-read choice is made after the winner is known.
  assign req = s_wvalid | s_arvalid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Pointer moves to the requester after the one just served.
  always_comb begin
    if (grant_q == IDX_W'(NUM_REQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= s_wvalid[pick_idx] ? WADDR : RADDR;
          end
        end
        WADDR: begin
          if (m_wvalid && m_wready) begin
            state_q <= WRESP;
          end
        end
        WRESP: begin
          if (m_bvalid && m_bready) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        RADDR: begin
          if (m_arvalid && m_aready) begin
            state_q <= RRESP;
          end
        end
        RRESP: begin
          if (m_rvalid && m_rready) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Payload muxes follow the grant regardless of state; only the
  // handshake signals are gated by the FSM.
  assign m_waddr = s_waddr[grant_q];
  assign m_wdata = s_wdata[grant_q];
  assign m_raddr = s_raddr[grant_q];

  always_comb begin
    s_wready  = '0;
    s_bvalid  = '0;
    s_aready  = '0;
    s_rvalid  = '0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    case (state_q)
      WADDR: begin
        m_wvalid          = s_wvalid[grant_q];
        s_wready[grant_q] = m_wready;
      end
      WRESP: begin
        m_bready          = s_bready[grant_q];
        s_bvalid[grant_q] = m_bvalid;
      end
      RADDR: begin
        m_arvalid         = s_arvalid[grant_q];
        s_aready[grant_q] = m_aready;
      end
      RRESP: begin
        m_rready          = s_rready[grant_q];
        s_rvalid[grant_q] = m_rvalid;
      end
      default: ;
    endcase
  end

  // Response data is broadcast; each requester qualifies it with its valid.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bcast
    assign s_bdata[i] = m_bdata;
    assign s_rdata[i] = m_rdata;
  end

  assign grant_idx = grant_q;
  assign busy      = busy_q;

endmodule : ps_arbiter
`default_nettype wire

// File: tb/tb_ps_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps_arbiter
// Purpose : Self-checking bench for ps_arbiter (directed vectors plus a
//           protocol-obeying random stress phase with a scoreboard).
// Rev     : 1.0  initial release
// ============================================================================
module tb_ps_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0][AW-1:0] s_waddr, s_raddr;
  logic [N-1:0][DW-1:0] s_wdata, s_bdata, s_rdata;
  logic [N-1:0]         s_wvalid, s_bready, s_arvalid, s_rready;
  logic [N-1:0]         s_wready, s_bvalid, s_aready, s_rvalid;
  logic [AW-1:0]        m_waddr, m_raddr;
  logic [DW-1:0]        m_wdata, m_bdata, m_rdata;
  logic                 m_wvalid, m_bready, m_arvalid, m_rready;
  logic                 m_wready, m_bvalid, m_aready, m_rvalid;
  logic [1:0]           grant_idx;
  logic                 busy;

  ps_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_bready(s_bready),
    .s_raddr(s_raddr), .s_arvalid(s_arvalid), .s_rready(s_rready),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bdata(s_bdata),
    .s_aready(s_aready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_bready(m_bready),
    .m_raddr(m_raddr), .m_arvalid(m_arvalid), .m_rready(m_rready),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bdata(m_bdata),
    .m_aready(m_aready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .grant_idx(grant_idx), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_waddr = '0; s_wdata = '0; s_wvalid = '0; s_bready = '0;
    s_raddr = '0; s_arvalid = '0; s_rready = '0;
    m_wready = 1'b0; m_bvalid = 1'b0; m_bdata = '0;
    m_aready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // random-phase state
  int           st [N];    // 0 idle, 1 write addr, 2 wait b, 3 read addr, 4 wait r
  int           issued [N];
  int           completed [N];
  logic [N-1:0] hs_req, hs_resp, exp_oh;
  logic         outstanding, owner_wr, draining, all_idle;
  int           owner;

  initial begin
    clear_inputs();

    // ---- reset overrides active requests ----
    rst = 1'b1;
    s_wvalid = '1; s_arvalid = '1; m_wready = 1'b1; m_aready = 1'b1;
    m_bvalid = 1'b1; m_rvalid = 1'b1; s_bready = '1; s_rready = '1;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_ptr", dut.rr_ptr_q, 0);
    check("rst_m_hs", {m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    check("rst_s_hs", {s_wready, s_bvalid, s_aready, s_rvalid}, 0);

    // ---- single write from requester 2 ----
    do_reset();
    s_wvalid[2] = 1'b1; s_waddr[2] = 5'h05; s_wdata[2] = 32'hDEADBEEF;
    s_bready[2] = 1'b1; m_wready = 1'b1;
    #1;
    check("wr_c0_busy", busy, 0);
    check("wr_c0_wvalid", m_wvalid, 0);
    tick();
    check("wr_c1_busy", busy, 1);
    check("wr_c1_grant", grant_idx, 2);
    check("wr_c1_wvalid", m_wvalid, 1);
    check("wr_c1_waddr", m_waddr, 5'h05);
    check("wr_c1_wdata", m_wdata, 32'hDEADBEEF);
    check("wr_c1_wready", s_wready, 4'b0100);
    check("wr_c1_arvalid", m_arvalid, 0);
    tick();
    s_wvalid[2] = 1'b0; m_bvalid = 1'b1; m_bdata = 32'h12345678;
    #1;
    check("wr_c2_bvalid", s_bvalid, 4'b0100);
    check("wr_c2_bready", m_bready, 1);
    check("wr_c2_bdata", s_bdata[2], 32'h12345678);
    check("wr_c2_wvalid", m_wvalid, 0);
    tick();
    m_bvalid = 1'b0;
    #1;
    check("wr_c3_busy", busy, 0);
    check("wr_c3_ptr", dut.rr_ptr_q, 3);
    check("wr_c3_bvalid", s_bvalid, 0);

    // ---- four-way read contention: grants 0,1,2,3,0 ----
    do_reset();
    s_arvalid = '1; s_rready = '1; m_aready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hA5A5_0000;
    for (int i = 0; i < N; i++) s_raddr[i] = AW'(i + 8);
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_oh = '0; exp_oh[k % N] = 1'b1;
      check("ct_idle_busy", busy, 0);
      check("ct_idle_rvalid", s_rvalid, 0);
      tick();
      check("ct_grant", grant_idx, k % N);
      check("ct_aready", s_aready, exp_oh);
      check("ct_raddr", m_raddr, (k % N) + 8);
      tick();
      check("ct_rvalid", s_rvalid, exp_oh);
      check("ct_rdata", s_rdata[k % N], 32'hA5A5_0000);
      tick();
    end

    // ---- write then read from requester 1 ----
    do_reset();
    s_wvalid[1] = 1'b1; s_arvalid[1] = 1'b1; s_waddr[1] = 5'h11; s_raddr[1] = 5'h12;
    s_bready = '1; s_rready = '1;
    m_wready = 1'b1; m_aready = 1'b1; m_bvalid = 1'b1; m_rvalid = 1'b1;
    #1;
    tick();
    check("wr1_grant", grant_idx, 1);
    check("wr1_wvalid", m_wvalid, 1);
    check("wr1_arvalid", m_arvalid, 0);
    check("wr1_aready", s_aready, 0);
    tick();
    s_wvalid[1] = 1'b0;
    #1;
    check("wr1_bvalid", s_bvalid, 4'b0010);
    tick();
    check("wr1_idle_busy", busy, 0);
    check("wr1_ptr", dut.rr_ptr_q, 2);
    tick();
    check("rd1_grant", grant_idx, 1);
    check("rd1_arvalid", m_arvalid, 1);
    check("rd1_raddr", m_raddr, 5'h12);
    tick();
    s_arvalid[1] = 1'b0;
    #1;
    check("rd1_rvalid", s_rvalid, 4'b0010);
    tick();
    check("rd1_done_busy", busy, 0);
    check("rd1_ptr", dut.rr_ptr_q, 2);

    // ---- backpressure on both channels ----
    do_reset();
    s_wvalid[0] = 1'b1; s_waddr[0] = 5'h1F; s_wdata[0] = 32'hCAFEF00D; s_bready[0] = 1'b1;
    #1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_w_wvalid", m_wvalid, 1);
      check("bp_w_waddr", m_waddr, 5'h1F);
      check("bp_w_wdata", m_wdata, 32'hCAFEF00D);
      check("bp_w_wready", s_wready, 0);
      check("bp_w_bready", m_bready, 0);
      tick();
    end
    m_wready = 1'b1;
    #1;
    check("bp_w_hs", s_wready, 4'b0001);
    tick();
    s_wvalid[0] = 1'b0; m_bvalid = 1'b1;
    #1;
    check("bp_b_bvalid", s_bvalid, 4'b0001);
    tick();
    m_bvalid = 1'b0;
    s_arvalid[0] = 1'b1; s_raddr[0] = 5'h03; m_aready = 1'b1;
    #1;
    tick();
    check("bp_r_grant", grant_idx, 0);
    tick();
    s_arvalid[0] = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00005A5A;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_r_rvalid", s_rvalid, 4'b0001);
      check("bp_r_rready", m_rready, 0);
      check("bp_r_busy", busy, 1);
      tick();
    end
    s_rready[0] = 1'b1;
    #1;
    check("bp_r_hs", m_rready, 1);
    tick();
    m_rvalid = 1'b0;
    #1;
    check("bp_done_busy", busy, 0);

    // ---- reset while a write response is pending ----
    do_reset();
    s_wvalid[3] = 1'b1; m_wready = 1'b1;
    #1;
    tick();
    tick();
    s_wvalid[3] = 1'b0; m_bvalid = 1'b1;
    #1;
    check("rm_pending", s_bvalid, 4'b1000);
    rst = 1'b1;
    tick();
    check("rm_busy", busy, 0);
    check("rm_grant", grant_idx, 0);
    check("rm_bvalid", s_bvalid, 0);
    check("rm_bready", m_bready, 0);
    rst = 1'b0;
    s_arvalid[1] = 1'b1; m_aready = 1'b1; s_rready[1] = 1'b1;
    #1;
    tick();
    check("rm_new_grant", grant_idx, 1);
    check("rm_new_arvalid", m_arvalid, 1);
    check("rm_new_bvalid", s_bvalid, 0);
    tick();
    s_arvalid[1] = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b1;
    #1;
    check("rm_new_rvalid", s_rvalid, 4'b0010);
    tick();
    m_rvalid = 1'b0;

    // ---- random stress against a scoreboard ----
    do_reset();
    for (int i = 0; i < N; i++) begin
      st[i] = 0; issued[i] = 0; completed[i] = 0;
    end
    hs_req = '0; hs_resp = '0; outstanding = 1'b0; owner = 0; owner_wr = 1'b0;
    draining = 1'b0; all_idle = 1'b0;
    for (int cyc = 0; cyc < 2300; cyc++) begin
      if (cyc == 2000) draining = 1'b1;
      tick();
      for (int i = 0; i < N; i++) begin
        case (st[i])
          1: if (hs_req[i]) begin s_wvalid[i] = 1'b0; st[i] = 2; end
          2: if (hs_resp[i]) st[i] = 0;
          3: if (hs_req[i]) begin s_arvalid[i] = 1'b0; st[i] = 4; end
          4: if (hs_resp[i]) st[i] = 0;
          default: begin
            if (!draining && $urandom_range(0, 3) == 0) begin
              issued[i]++;
              if ($urandom_range(0, 1) == 1) begin
                st[i] = 1; s_wvalid[i] = 1'b1;
                s_waddr[i] = AW'($urandom); s_wdata[i] = $urandom;
              end else begin
                st[i] = 3; s_arvalid[i] = 1'b1; s_raddr[i] = AW'($urandom);
              end
            end
          end
        endcase
        s_bready[i] = draining | ($urandom_range(0, 1) == 1);
        s_rready[i] = draining | ($urandom_range(0, 1) == 1);
      end
      m_wready = draining | ($urandom_range(0, 1) == 1);
      m_aready = draining | ($urandom_range(0, 1) == 1);
      m_bvalid = draining | ($urandom_range(0, 1) == 1);
      m_rvalid = draining | ($urandom_range(0, 1) == 1);
      m_bdata  = $urandom;
      m_rdata  = $urandom;
      #1;
      hs_req  = (s_wready & s_wvalid) | (s_aready & s_arvalid);
      hs_resp = (s_bvalid & s_bready) | (s_rvalid & s_rready);
      if ((m_wvalid && m_wready) || (m_arvalid && m_aready)) begin
        check("rnd_addr_no_overlap", outstanding, 0);
        check("rnd_addr_onehot", $countones(hs_req), 1);
        for (int i = 0; i < N; i++) if (hs_req[i]) owner = i;
        owner_wr = m_wvalid && m_wready;
        check("rnd_addr_owner_state", st[owner], owner_wr ? 1 : 3);
        if (owner_wr) check("rnd_waddr_payload", m_waddr, s_waddr[owner]);
        else          check("rnd_raddr_payload", m_raddr, s_raddr[owner]);
        outstanding = 1'b1;
      end else begin
        if (hs_req != '0) check("rnd_spurious_addr_hs", hs_req, 0);
      end
      if ((m_bvalid && m_bready) || (m_rvalid && m_rready)) begin
        check("rnd_resp_outstanding", outstanding, 1);
        check("rnd_resp_kind", m_bvalid && m_bready, owner_wr);
        exp_oh = '0; exp_oh[owner] = 1'b1;
        check("rnd_resp_route", hs_resp, exp_oh);
        completed[owner]++;
        outstanding = 1'b0;
      end else begin
        if (hs_resp != '0) check("rnd_spurious_resp", hs_resp, 0);
      end
      if (draining) begin
        all_idle = !outstanding && (hs_resp == '0);
        for (int i = 0; i < N; i++) if (st[i] != 0) all_idle = 1'b0;
        if (all_idle) break;
      end
    end
    check("rnd_drained", all_idle, 1);
    for (int i = 0; i < N; i++) begin
      check("rnd_issued_eq_completed", completed[i], issued[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ps_arbiter
`default_nettype wire
